// File: rtl/mem_port_pkg.sv
// Shared types for mem_port_arbiter.
// FSM states, requester port ids and the SRAM/SPI address split.
package mem_port_pkg;

    typedef enum logic [2:0] {
        MPA_IDLE,
        MPA_ISSUE,
        MPA_WAIT_RD,
        MPA_WAIT_WR,
        MPA_RESP
    } mpa_state_e;

    typedef enum logic {
        PORT_DATA  = 1'b0,
        PORT_INSTR = 1'b1
    } mpa_port_e;

    localparam logic [31:0] SRAM_LIMIT_DEFAULT = 32'h0000_2000;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin arbiter, one-hot grant.
// Priority flips to the non-granted requester when advance_i is set.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[prio_q]) begin
            gnt_o[prio_q] = 1'b1;
        end else if (req_i[~prio_q]) begin
            gnt_o[~prio_q] = 1'b1;
        end
    end

    // granting requester 0 hands priority to requester 1 and vice versa
    assign prio_d = advance_i ? gnt_o[0] : prio_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data front end for storage_controller: one transaction
// at a time, external writes rejected, stuck external reads timed out.
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int unsigned MEM_W          = 32,
    parameter logic [31:0] SRAM_LIMIT     = SRAM_LIMIT_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_req_i,
    input  logic [31:0]        instr_addr_i,
    output logic               instr_gnt_o,
    output logic               instr_rvalid_o,
    output logic [MEM_W-1:0]   instr_rdata_o,
    output logic               instr_err_o,
    input  logic               data_req_i,
    input  logic               data_we_i,
    input  logic [MEM_W/8-1:0] data_be_i,
    input  logic [31:0]        data_addr_i,
    input  logic [MEM_W-1:0]   data_wdata_i,
    output logic               data_gnt_o,
    output logic               data_rvalid_o,
    output logic [MEM_W-1:0]   data_rdata_o,
    output logic               data_err_o,
    output logic               mem_access_o,
    output logic               mem_we_o,
    output logic [31:0]        mem_addr_o,
    output logic [MEM_W-1:0]   mem_wdata_o,
    output logic [MEM_W/8-1:0] mem_be_o,
    input  logic [MEM_W-1:0]   mem_rdata_i,
    input  logic               mem_valid_i,
    output logic               fault_o
);

    localparam int unsigned BE_W  = MEM_W / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    mpa_state_e         state_q, state_d;
    mpa_port_e          owner_q, owner_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [MEM_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [MEM_W-1:0]   rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               byp_q, byp_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         arb_gnt;
    logic               idle;
    logic               grant;
    logic               sel_instr;
    logic               g_we;
    logic [31:0]        g_addr;
    logic [BE_W-1:0]    g_be;
    logic [MEM_W-1:0]   g_wdata;
    logic               g_byp;
    logic               mem_on;
    logic               resp;

    assign idle  = (state_q == MPA_IDLE);
    assign grant = idle & (|arb_gnt);

    rr_arbiter2 u_arb (
        .clk_i     (clk),
        .rst_ni    (rst),
        .req_i     ({instr_req_i, data_req_i}),
        .advance_i (grant),
        .gnt_o     (arb_gnt)
    );

    assign data_gnt_o  = rst & idle & arb_gnt[0];
    assign instr_gnt_o = rst & idle & arb_gnt[1];

    always_comb begin
        sel_instr = arb_gnt[1];
        g_we      = sel_instr ? 1'b0 : data_we_i;
        g_addr    = sel_instr ? instr_addr_i : data_addr_i;
        g_be      = sel_instr ? '1 : data_be_i;
        g_wdata   = sel_instr ? '0 : data_wdata_i;
        // external writes, and external reads once faulted, never reach the controller
        g_byp     = (g_addr >= SRAM_LIMIT) & (g_we | fault_q);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        byp_d   = byp_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MPA_IDLE: begin
                if (grant) begin
                    owner_d = sel_instr ? PORT_INSTR : PORT_DATA;
                    we_d    = g_we;
                    addr_d  = g_addr;
                    wdata_d = g_wdata;
                    be_d    = g_be;
                    rdata_d = '0;
                    err_d   = g_byp;
                    byp_d   = g_byp;
                    state_d = g_byp ? MPA_RESP : MPA_ISSUE;
                end
            end
            MPA_ISSUE: begin
                cnt_d   = '0;
                state_d = we_q ? MPA_WAIT_WR : MPA_WAIT_RD;
            end
            MPA_WAIT_WR: begin
                state_d = MPA_RESP;
            end
            MPA_WAIT_RD: begin
                if (mem_valid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = MPA_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    fault_d = 1'b1;
                    state_d = MPA_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MPA_RESP: begin
                state_d = MPA_IDLE;
            end
            default: begin
                state_d = MPA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MPA_IDLE;
            owner_q <= PORT_DATA;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            byp_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            byp_q   <= byp_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_on       = ~idle & ~byp_q;
    assign mem_access_o = (state_q == MPA_ISSUE);
    assign mem_we_o     = mem_on & we_q;
    assign mem_addr_o   = mem_on ? addr_q : '0;
    assign mem_wdata_o  = mem_on ? wdata_q : '0;
    assign mem_be_o     = mem_on ? be_q : '0;

    assign resp           = (state_q == MPA_RESP);
    assign data_rvalid_o  = resp & (owner_q == PORT_DATA);
    assign instr_rvalid_o = resp & (owner_q == PORT_INSTR);
    assign data_rdata_o   = data_rvalid_o ? rdata_q : '0;
    assign instr_rdata_o  = instr_rvalid_o ? rdata_q : '0;
    assign data_err_o     = data_rvalid_o & err_q;
    assign instr_err_o    = instr_rvalid_o & err_q;
    assign fault_o        = fault_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the port rules.
module tb_mem_port_arbiter;
    import mem_port_pkg::*;

    localparam int          TO  = 16;
    localparam logic [31:0] LIM = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_access_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_valid_i = 1'b0;
    logic        fault_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ext_dly = 0;
    logic [31:0] env_sram [2048];
    logic [31:0] ref_sram [2048];
    bit m_prio_instr = 1'b0;
    bit m_fault = 1'b0;

    mem_port_arbiter #(
        .MEM_W(32), .SRAM_LIMIT(LIM), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .data_err_o(data_err_o), .mem_access_o(mem_access_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i), .mem_valid_i(mem_valid_i),
        .fault_o(fault_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ext_val(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // storage_controller stand-in: SRAM answers in WAIT_RD's first
    // cycle, SPI after ext_dly extra cycles (never when negative)
    initial begin : responder
        int i;
        int d;
        logic [31:0] ra;
        forever begin
            @(negedge clk);
            if (rst && mem_access_o) begin
                if (mem_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be_o[b])
                            env_sram[mem_addr_o[12:2]][8*b+:8] = mem_wdata_o[8*b+:8];
                end else begin
                    ra = mem_addr_o;
                    d = (ra < LIM) ? 0 : ext_dly;
                    if (d >= 0) begin
                        i = 0;
                        while (i <= d && rst) begin
                            @(negedge clk);
                            i++;
                        end
                        if (rst) begin
                            mem_valid_i = 1'b1;
                            mem_rdata_i = (ra < LIM) ? env_sram[ra[12:2]] : ext_val(ra);
                        end
                        @(negedge clk);
                        mem_valid_i = 1'b0;
                        mem_rdata_i = 32'hBAD0_BAD0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, {instr_gnt_o, data_gnt_o}, 0);
        chk({tag, "_rvalid"}, {instr_rvalid_o, data_rvalid_o}, 0);
        chk({tag, "_err"}, {instr_err_o, data_err_o}, 0);
        chk({tag, "_rdata"}, {instr_rdata_o, data_rdata_o}, 0);
        chk({tag, "_access"}, {mem_access_o, mem_we_o}, 0);
        chk({tag, "_maddr"}, mem_addr_o, 0);
        chk({tag, "_mwdata"}, mem_wdata_o, 0);
        chk({tag, "_mbe"}, mem_be_o, 0);
        chk({tag, "_fault"}, fault_o, 0);
    endtask

    task automatic drive(input bit pi, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        if (pi) begin
            instr_req_i = 1'b1;
            instr_addr_i = a;
        end else begin
            data_req_i = 1'b1;
            data_we_i = we;
            data_addr_i = a;
            data_wdata_i = wd;
            data_be_i = be;
        end
    endtask

    task automatic drop(input bit pi);
        if (pi) begin
            instr_req_i = 1'b0;
            instr_addr_i = $urandom;
        end else begin
            data_req_i = 1'b0;
            data_we_i = 1'($urandom_range(0, 1));
            data_addr_i = $urandom;
            data_wdata_i = $urandom;
            data_be_i = 4'($urandom_range(0, 15));
        end
    endtask

    // Waits for the grant of an already-driven request and checks the
    // whole response timeline against the model.
    task automatic serve(input bit pi, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output int gcyc, output int lat);
        bit ext, w, byp, eerr;
        logic [31:0] erd;
        logic [3:0] ebe;
        int n;
        w = !pi && we;
        ext = (a >= LIM);
        ebe = pi ? 4'hF : be;
        byp = 1'b0;
        eerr = 1'b0;
        erd = '0;
        if (ext && (w || m_fault)) begin
            byp = 1'b1;
            eerr = 1'b1;
            lat = 1;
        end else if (w) begin
            lat = 3;
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_sram[a[12:2]][8*b+:8] = wd[8*b+:8];
        end else if (!ext) begin
            lat = 3;
            erd = ref_sram[a[12:2]];
        end else if (ext_dly >= 0) begin
            lat = 3 + ext_dly;
            erd = ext_val(a);
        end else begin
            lat = TO + 2;
            eerr = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(instr_gnt_o || data_gnt_o) && n < 64);
        gcyc = cyc;
        if (!(instr_gnt_o || data_gnt_o)) begin
            chk("gnt_wait", 0, 1);
            lat = 0;
            drop(pi);
            return;
        end
        chk("gnt", {instr_gnt_o, data_gnt_o}, {pi, !pi});
        m_prio_instr = !pi;
        @(posedge clk);
        #1 drop(pi);
        for (int t = 1; t <= lat; t++) begin
            @(negedge clk);
            chk("access", mem_access_o, (t == 1) && !byp);
            if (!byp) begin
                chk("mem_addr", mem_addr_o, a);
                chk("mem_we", mem_we_o, w);
                chk("mem_be", mem_be_o, ebe);
                if (w) chk("mem_wdata", mem_wdata_o, wd);
            end
            chk("rvalid_own", pi ? instr_rvalid_o : data_rvalid_o, t == lat);
            chk("rvalid_other", pi ? data_rvalid_o : instr_rvalid_o, 0);
            if (t == lat) begin
                if (eerr && !byp) m_fault = 1'b1;
                chk("rdata", pi ? instr_rdata_o : data_rdata_o, erd);
                chk("err", pi ? instr_err_o : data_err_o, eerr);
                chk("fault", fault_o, m_fault);
            end
        end
    endtask

    task automatic single(input bit pi, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        int g, l;
        @(posedge clk);
        #1 drive(pi, we, a, wd, be);
        serve(pi, we, a, wd, be, g, l);
    endtask

    task automatic dual(input logic [31:0] ia, input bit dwe, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [3:0] dbe);
        int g1, l1, g2, l2;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, ia, '0, '0);
        drive(1'b0, dwe, da, dwd, dbe);
        if (m_prio_instr) begin
            serve(1'b1, 1'b0, ia, '0, '0, g1, l1);
            serve(1'b0, dwe, da, dwd, dbe, g2, l2);
        end else begin
            serve(1'b0, dwe, da, dwd, dbe, g1, l1);
            serve(1'b1, 1'b0, ia, '0, '0, g2, l2);
        end
        chk("rr_gap", g2 - g1, l1 + 1);
    endtask

    task automatic rnd(input bit pi, output bit we, output logic [31:0] a,
                       output logic [31:0] wd, output logic [3:0] be);
        we = pi ? 1'b0 : 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 3)
            a = LIM + (32'($urandom_range(0, 65535)) << 2);
        else
            a = 32'($urandom_range(0, 2047)) << 2;
        wd = $urandom;
        be = 4'($urandom_range(0, 15));
    endtask

    task automatic rand_phase(input int iters, input bit allow_ext);
        bit we, we2;
        logic [31:0] a, a2, wd, wd2;
        logic [3:0] be, be2;
        bit pi;
        for (int k = 0; k < iters; k++) begin
            ext_dly = allow_ext ? $urandom_range(0, 8) : -1;
            if ($urandom_range(0, 2) == 0) begin
                rnd(1'b1, we, a, wd, be);
                rnd(1'b0, we2, a2, wd2, be2);
                dual(a, we2, a2, wd2, be2);
            end else begin
                pi = 1'($urandom_range(0, 1));
                rnd(pi, we, a, wd, be);
                single(pi, we, a, wd, be);
            end
        end
    endtask

    initial begin : main
        int n;
        for (int i = 0; i < 2048; i++) begin
            env_sram[i] = $urandom;
            ref_sram[i] = env_sram[i];
        end
        env_sram[32'h40] = 32'hDEAD_BEEF;
        ref_sram[32'h40] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        dual(32'h0000_0040, 1'b0, 32'h0000_0080, '0, 4'hF);
        single(1'b0, 1'b0, 32'h0000_0100, '0, 4'hF);
        single(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011);
        single(1'b0, 1'b0, 32'h0000_0010, '0, 4'hF);
        single(1'b0, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'hF);
        single(1'b0, 1'b1, 32'h0000_1FFC, 32'hA1B2_C3D4, 4'hF);
        single(1'b1, 1'b0, 32'h0000_1FFC, '0, '0);
        ext_dly = 5;
        single(1'b1, 1'b0, 32'h0000_2000, '0, '0);

        rand_phase(40, 1'b1);

        ext_dly = -1;
        single(1'b1, 1'b0, 32'h0001_0000, '0, '0);
        single(1'b0, 1'b0, 32'h0000_3000, '0, 4'hF);
        single(1'b1, 1'b0, 32'h0002_0000, '0, '0);
        single(1'b0, 1'b0, 32'h0000_0100, '0, 4'hF);
        single(1'b0, 1'b1, 32'h0000_4000, 32'h1, 4'hF);

        rand_phase(25, 1'b0);

        @(posedge clk);
        #1 drive(1'b0, 1'b0, 32'h0000_0200, '0, 4'hF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_gnt_o && n < 64);
        chk("rst_setup_gnt", data_gnt_o, 1);
        @(posedge clk);
        #1 drop(1'b0);
        @(negedge clk);
        chk("rst_setup_issue", mem_access_o, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("rst_async");
        m_prio_instr = 1'b0;
        m_fault = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_stale", {instr_rvalid_o, data_rvalid_o}, 0);
        end
        dual(32'h0000_0044, 1'b0, 32'h0000_0084, '0, 4'hF);
        ext_dly = 2;
        single(1'b0, 1'b0, 32'h0000_5000, '0, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Upstream front end of `storage_controller`. Accepts instruction-fetch and data requests from the vector core on two req/gnt/rvalid ports and arbitrates them round-robin. Issues one request at a time onto the controller's single-pulse `memory_access` interface and returns read data, write acknowledges, or errors. Shields the controller from illegal or hanging accesses: external writes are rejected, and stuck external reads are timed out.

## Interface
- `MEM_W`, 32, data bus width in bits; matches `storage_controller`.
- `SRAM_LIMIT`, 32'h0000_2000, first address served by external SPI storage.
- `TIMEOUT_CYCLES`, 1024, maximum cycles spent in WAIT_RD before an error response.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `instr_req_i` in 1: fetch request.
- `instr_addr_i` in 32: fetch address.
- `instr_gnt_o` out 1: fetch accepted.
- `instr_rvalid_o` out 1: fetch response, 1-cycle pulse.
- `instr_rdata_o` out MEM_W: fetch data.
- `instr_err_o` out 1: fetch error, qualified by rvalid.
- `data_req_i` in 1: data request.
- `data_we_i` in 1: data write.
- `data_be_i` in MEM_W/8: byte enables.
- `data_addr_i` in 32: data address.
- `data_wdata_i` in MEM_W: write data.
- `data_gnt_o`, `data_rvalid_o`, `data_rdata_o`, `data_err_o`: as for the fetch port.
- `mem_access_o` out 1: one-cycle issue pulse, wired to `memory_access`.
- `mem_we_o` out 1: wired to `memory_is_writing`.
- `mem_addr_o` out 32: wired to `addr`.
- `mem_wdata_o` out MEM_W: wired to `d_in`.
- `mem_be_o` out MEM_W/8: wired to `mem_be`.
- `mem_rdata_i` in 32: from `d_out`.
- `mem_valid_i` in 1: from `out_valid`.
- `fault_o` out 1: sticky; set on timeout, cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP.
- Only one transaction is outstanding at a time.
- **IDLE**
  - Requests are arbitrated round-robin. After reset, the data port has priority.
  - After each grant, priority moves to the other port.
  - `*_gnt_o` is combinational, asserted only in IDLE, to at most one port.
  - On grant, addr, we, be and wdata are latched. The fetch port always latches we=0, be=all-ones.
  - A granted write with addr ≥ SRAM_LIMIT is illegal: go directly to RESP with err=1; nothing is issued.
  - Any other grant goes to ISSUE.
- **ISSUE**
  - `mem_access_o`=1 for exactly one cycle.
  - Next state: WAIT_WR if write, else WAIT_RD.
- **mem_* outputs**: held at the latched values from ISSUE until RESP is left. They are 0 in IDLE.
- **WAIT_WR**
  - One cycle (the controller's SRAM write cycle), then RESP with err=0, rdata=0.
  - `mem_valid_i` is ignored in this state.
- **WAIT_RD**
  - On `mem_valid_i`: capture `mem_rdata_i`, go to RESP with err=0.
  - The timeout counter increments every cycle in this state. When it reaches TIMEOUT_CYCLES-1 without valid: go to RESP with err=1, rdata=0, and set `fault_o`.
- **RESP**
  - `rvalid`, `rdata` and `err` are driven to the port that owns the transaction, for one cycle.
  - The non-owning port's rvalid stays 0.
  - Next state: IDLE.
- While `fault_o`=1, all subsequent reads with addr ≥ SRAM_LIMIT are answered immediately (IDLE→RESP) with err=1. SRAM accesses continue normally.
- The counter is `$clog2(TIMEOUT_CYCLES)` bits wide, cleared on entry to WAIT_RD.

## Timing
- **Reset values**: all outputs 0; state IDLE; priority = data port; `fault_o`=0.
- **Reset mid-transaction**: the transaction is abandoned immediately and no response is produced.
- **SRAM read**:
  - Grant at T, `mem_access_o` at T+1.
  - The controller asserts out_valid at T+2 (combinational); the arbiter captures it at T+2.
  - rvalid at T+3.
- **SRAM write**: grant T, issue T+1, WAIT_WR T+2, rvalid T+3.
- **Back-to-back**: earliest next grant is T+4, which guarantees the controller is back in its default state before the next issue.
- **Illegal write or faulted external read**: grant T, rvalid T+1.
- **External read**: rvalid one cycle after the cycle `mem_valid_i` is seen. Worst case is TIMEOUT_CYCLES+2 cycles after grant.
- **Requester protocol**: a requester holds req/addr/data until gnt. The arbiter never depends on req after gnt.
- **Simultaneous req on both ports**: the priority holder wins; the other port waits, with gnt=0.

## Structure
- Package `mem_port_pkg` contains:
  - the state enum `mpa_state_e`;
  - the port-id typedef `mpa_port_e` {PORT_DATA, PORT_INSTR};
  - the default constant `SRAM_LIMIT_DEFAULT` = 32'h0000_2000.
- One sub-module, `rr_arbiter2`: two requests in, one-hot grant out, priority flip on an `advance` input. It is reused later for more ports.

## Test plan
- Data read at 0x0000_0100, SRAM model returns 0xDEAD_BEEF → `data_rvalid_o` at T+3, rdata=0xDEAD_BEEF, err=0; exactly one `mem_access_o` pulse.
- Both ports request at once from reset (fetch 0x40, data 0x80) → data granted first, fetch granted at T+4; responses return to the correct ports in order.
- Data write 0x0000_0010, wdata 0x1234_5678, be=4'b0011 → mem_we/addr/wdata/be held stable over T+1..T+3; rvalid at T+3, err=0.
- Data write to 0x0000_2000 → rvalid at T+1, err=1; `mem_access_o` never asserted.
- Fetch from 0x0001_0000, `mem_valid_i` never asserted, TIMEOUT_CYCLES=16 → err=1, rdata=0 at T+18; `fault_o` stays 1. A following external read errors at T+1; an SRAM read succeeds.
- Assert `rst` low in WAIT_RD → all outputs 0 asynchronously; after release, priority = data port and no stale rvalid.
